vga_timing_generator: RTL and testbench
=======================================

VGA_TIMING_GENERATOR -- requirements
Module: vga_timing_generator

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  H_ACTIVE 640 visible pixels per line; H_FP 16 front porch; H_SYNC 96 sync width; H_BP 48 back porch
  V_ACTIVE 480 visible lines; V_FP 10 front porch; V_SYNC 2 sync lines; V_BP 33 back porch
REQ-002 SHALL have ports, one per line: name direction width meaning:
  clock25MHz  in  1  pixel clock, all logic on rising edge
  reset  in  1  asynchronous, active-low reset
  x  out  10  current horizontal count, to pattern generator
  y  out  10  current vertical count, to pattern generator
  video_on  out  1  high while x<H_ACTIVE and y<V_ACTIVE
  line_start  out  1  one-cycle pulse, x==0
  frame_start  out  1  one-cycle pulse, x==0 and y==0
  red/green/blue  in  4 each  pattern colour for current (x,y), combinational from pattern
  vga_red/vga_green/vga_blue  out  4 each  registered, blanked colour to DAC
  vga_hsync  out  1  registered horizontal sync, active-low
  vga_vsync  out  1  registered vertical sync, active-low
  frame_count  out  16  frames completed (see Configuration)

Function
REQ-003 SHALL count h_count 0..H_TOTAL-1 (H_TOTAL = sum of H_* = 800), incrementing every clock; at H_TOTAL-1 it wraps to 0.
REQ-004 SHALL increment v_count 0..V_TOTAL-1 (525) only when h_count wraps; at h_count==799 and v_count==524, both wrap to 0 on the same edge.
REQ-005 x SHALL equal h_count and y SHALL equal v_count (raw, not clamped); video_on, line_start and frame_start SHALL be combinational decodes of the counters.
REQ-006 Raw hsync SHALL be low for h_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751], high otherwise.
REQ-007 Raw vsync SHALL be low for v_count in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491], across whole lines, high otherwise.
REQ-008 vga_hsync/vga_vsync SHALL be raw sync registered once (1-cycle latency) so they align with registered colour.
REQ-009 vga_red/green/blue SHALL register red/green/blue when video_on=1, and register 0 when video_on=0; latency exactly 1 clock from the (x,y) that produced them.
REQ-010 Counter widths SHALL be 10 bits; all parameter sums SHALL fit in 10 bits (max 1023); no other overflow path exists.

Reset
REQ-011 reset low SHALL immediately, without a clock, force: h_count=0, v_count=0, vga_red/green/blue=0, vga_hsync=1, vga_vsync=1, frame_count=0.
REQ-012 During reset: x=0, y=0, video_on=1, line_start=1, frame_start=1 (decodes of zero counters).
REQ-013 Reset asserted mid-line/mid-frame SHALL abandon the frame; first edge after release SHALL advance h_count to 1 (pixel 0 presented during reset and first cycle).

Configuration
REQ-014 Macro VGA_FRAME_COUNT_EN defined: frame_count SHALL increment by 1 on the edge where both counters wrap to 0, modulo 2^16 (0xFFFF -> 0x0000).
REQ-015 VGA_FRAME_COUNT_EN undefined: frame_count port SHALL remain and be tied to constant 0; no counter register is instantiated.

Verification
REQ-016 Release reset, count clocks -> x runs 0..799, y steps 0->1 on edge 800; frame_start high only at count 0 and again at clock 420000.
REQ-017 Observe vga_hsync over one line -> low exactly 96 clocks, first low sample the cycle after x==656, high again the cycle after x==752.
REQ-018 Observe vga_vsync -> low exactly 1600 clocks, starting the cycle after (x=0,y=490), ending the cycle after (x=0,y=492).
REQ-019 Drive red=green=blue=4'hF constant -> vga_* = 4'hF for the cycles after x=0..639 with y<480, 0 for the cycles after x=640..799 and during y=480..524.
REQ-020 Assert reset at x=300,y=200 with no clock edge -> all outputs take REQ-011/REQ-012 values at once; after release, next frame_start after 420000 clocks.
REQ-021 With VGA_FRAME_COUNT_EN, preload via 65536 frames (or force) frame_count=0xFFFF -> next wrap gives 0x0000; without macro, frame_count stays 0 across 3 frames.

Source files
------------

// File: rtl/vga_timing_generator.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_generator
// Description : VGA raster counters, sync generation and blanked colour output.
//               Define VGA_FRAME_COUNT_EN to enable the frame counter.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_timing_generator #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33
) (
  input  logic        clock25MHz,
  input  logic        reset,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start,
  input  logic [3:0]  red,
  input  logic [3:0]  green,
  input  logic [3:0]  blue,
  output logic [3:0]  vga_red,
  output logic [3:0]  vga_green,
  output logic [3:0]  vga_blue,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic [15:0] frame_count
);

  localparam logic [9:0] c_h_active     = 10'(H_ACTIVE);
  localparam logic [9:0] c_h_last       = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] c_h_sync_start = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] c_h_sync_end   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] c_v_active     = 10'(V_ACTIVE);
  localparam logic [9:0] c_v_last       = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] c_v_sync_start = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] c_v_sync_end   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] r_h_count;
  logic [9:0] r_v_count;
  logic       w_h_last;
  logic       w_v_last;
  logic       w_hsync_raw;
  logic       w_vsync_raw;

  assign w_h_last = (r_h_count == c_h_last);
  assign w_v_last = (r_v_count == c_v_last);

  always_ff @(posedge clock25MHz or negedge reset) begin
    if (!reset) begin
      r_h_count <= '0;
      r_v_count <= '0;
    end else if (w_h_last) begin
      r_h_count <= '0;
      r_v_count <= w_v_last ? 10'd0 : r_v_count + 10'd1;
    end else begin
      r_h_count <= r_h_count + 10'd1;
    end
  end

  assign x           = r_h_count;
  assign y           = r_v_count;
  assign video_on    = (r_h_count < c_h_active) && (r_v_count < c_v_active);
  assign line_start  = (r_h_count == 10'd0);
  assign frame_start = (r_h_count == 10'd0) && (r_v_count == 10'd0);

  assign w_hsync_raw = !((r_h_count >= c_h_sync_start) && (r_h_count <= c_h_sync_end));
  assign w_vsync_raw = !((r_v_count >= c_v_sync_start) && (r_v_count <= c_v_sync_end));

  // Sync and colour share one register stage so they stay aligned at the DAC
  always_ff @(posedge clock25MHz or negedge reset) begin
    if (!reset) begin
      vga_red   <= '0;
      vga_green <= '0;
      vga_blue  <= '0;
      vga_hsync <= 1'b1;
      vga_vsync <= 1'b1;
    end else begin
      vga_red   <= video_on ? red   : 4'd0;
      vga_green <= video_on ? green : 4'd0;
      vga_blue  <= video_on ? blue  : 4'd0;
      vga_hsync <= w_hsync_raw;
      vga_vsync <= w_vsync_raw;
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] r_frame_count;

  always_ff @(posedge clock25MHz or negedge reset) begin
    if (!reset) begin
      r_frame_count <= '0;
    end else if (w_h_last && w_v_last) begin
      r_frame_count <= r_frame_count + 16'd1;
    end
  end

  assign frame_count = r_frame_count;
`else
  assign frame_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_generator.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_timing_generator
// Description : Scoreboard bench for vga_timing_generator (VGA and small raster).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_timing_generator;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
    logic       hs;
    logic       vs;
  } reg_t;

  typedef struct packed {
    reg_t f;
    reg_t s;
  } pair_t;

  logic        clock25MHz = 1'b0;
  logic        reset      = 1'b0;
  logic [3:0]  red        = 4'd0;
  logic [3:0]  green      = 4'd0;
  logic [3:0]  blue       = 4'd0;

  logic [9:0]  f_x, f_y, s_x, s_y;
  logic        f_von, f_ls, f_fs, s_von, s_ls, s_fs;
  logic [3:0]  f_r, f_g, f_b, s_r, s_g, s_b;
  logic        f_hs, f_vs, s_hs, s_vs;
  logic [15:0] f_fc, s_fc;

  int    total = 0;
  int    bad   = 0;
  int    n     = 0;
  bit    const_colour = 1'b1;
  pair_t sb[$];

  always #20 clock25MHz = ~clock25MHz;

  vga_timing_generator u_full (
    .clock25MHz (clock25MHz), .reset (reset),
    .x (f_x), .y (f_y), .video_on (f_von), .line_start (f_ls), .frame_start (f_fs),
    .red (red), .green (green), .blue (blue),
    .vga_red (f_r), .vga_green (f_g), .vga_blue (f_b),
    .vga_hsync (f_hs), .vga_vsync (f_vs), .frame_count (f_fc)
  );

  // Small raster: 16 clocks per line, 11 lines per frame
  vga_timing_generator #(
    .H_ACTIVE (8), .H_FP (2), .H_SYNC (3), .H_BP (3),
    .V_ACTIVE (6), .V_FP (1), .V_SYNC (2), .V_BP (2)
  ) u_small (
    .clock25MHz (clock25MHz), .reset (reset),
    .x (s_x), .y (s_y), .video_on (s_von), .line_start (s_ls), .frame_start (s_fs),
    .red (red), .green (green), .blue (blue),
    .vga_red (s_r), .vga_green (s_g), .vga_blue (s_b),
    .vga_hsync (s_hs), .vga_vsync (s_vs), .frame_count (s_fc)
  );

  function automatic reg_t exp_reg(input int cyc, input int ha, hf, hs, hb,
                                   input int va, vf, vs, vb,
                                   input logic [3:0] r, g, b);
    int   ht;
    int   vt;
    int   h;
    int   v;
    bit   on;
    reg_t e;
    ht   = ha + hf + hs + hb;
    vt   = va + vf + vs + vb;
    h    = cyc % ht;
    v    = (cyc / ht) % vt;
    on   = (h < ha) && (v < va);
    e.r  = on ? r : 4'd0;
    e.g  = on ? g : 4'd0;
    e.b  = on ? b : 4'd0;
    e.hs = !((h >= ha + hf) && (h < ha + hf + hs));
    e.vs = !((v >= va + vf) && (v < va + vf + vs));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_inst(input string p, input int ha, hf, hs, hb, input int va, vf, vs, vb,
                          input int cyc, input logic [9:0] ox, oy,
                          input logic ov, ol, ofs, input logic [15:0] ofc,
                          input reg_t oreg, input bit have, input reg_t ereg);
    int ht;
    int vt;
    int h;
    int v;
    int fc;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    h  = cyc % ht;
    v  = (cyc / ht) % vt;
`ifdef VGA_FRAME_COUNT_EN
    fc = (cyc / (ht * vt)) % 65536;
`else
    fc = 0;
`endif
    chk({p, ".x"}, 32'(ox), 32'(h));
    chk({p, ".y"}, 32'(oy), 32'(v));
    chk({p, ".video_on"}, 32'(ov), 32'((h < ha) && (v < va)));
    chk({p, ".line_start"}, 32'(ol), 32'(h == 0));
    chk({p, ".frame_start"}, 32'(ofs), 32'((h == 0) && (v == 0)));
    chk({p, ".frame_count"}, 32'(ofc), 32'(fc));
    if (have) begin
      chk({p, ".vga_red"}, 32'(oreg.r), 32'(ereg.r));
      chk({p, ".vga_green"}, 32'(oreg.g), 32'(ereg.g));
      chk({p, ".vga_blue"}, 32'(oreg.b), 32'(ereg.b));
      chk({p, ".vga_hsync"}, 32'(oreg.hs), 32'(ereg.hs));
      chk({p, ".vga_vsync"}, 32'(oreg.vs), 32'(ereg.vs));
    end
  endtask

  // Called at a falling edge: compare, then drive the next colour and record its expectation
  task automatic check_now();
    pair_t e;
    bit    have;
    have = (sb.size() > 0);
    e    = have ? sb.pop_front() : '0;
    chk_inst("full", 640, 16, 96, 48, 480, 10, 2, 33, n, f_x, f_y, f_von, f_ls, f_fs, f_fc,
             {f_r, f_g, f_b, f_hs, f_vs}, have, e.f);
    chk_inst("small", 8, 2, 3, 3, 6, 1, 2, 2, n, s_x, s_y, s_von, s_ls, s_fs, s_fc,
             {s_r, s_g, s_b, s_hs, s_vs}, have, e.s);
    if (const_colour) begin
      red   = 4'hF;
      green = 4'hF;
      blue  = 4'hF;
    end else begin
      red   = 4'($urandom_range(0, 15));
      green = 4'($urandom_range(0, 15));
      blue  = 4'($urandom_range(0, 15));
    end
    e.f = exp_reg(n, 640, 16, 96, 48, 480, 10, 2, 33, red, green, blue);
    e.s = exp_reg(n, 8, 2, 3, 3, 6, 1, 2, 2, red, green, blue);
    sb.push_back(e);
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      check_now();
      @(posedge clock25MHz);
      n++;
      @(negedge clock25MHz);
    end
  endtask

  task automatic reset_check();
    reg_t idle;
    idle = '{r: 4'd0, g: 4'd0, b: 4'd0, hs: 1'b1, vs: 1'b1};
    chk_inst("full_rst", 640, 16, 96, 48, 480, 10, 2, 33, 0, f_x, f_y, f_von, f_ls, f_fs, f_fc,
             {f_r, f_g, f_b, f_hs, f_vs}, 1'b1, idle);
    chk_inst("small_rst", 8, 2, 3, 3, 6, 1, 2, 2, 0, s_x, s_y, s_von, s_ls, s_fs, s_fc,
             {s_r, s_g, s_b, s_hs, s_vs}, 1'b1, idle);
  endtask

  // Reset is asserted between edges and checked before any clock arrives
  task automatic do_reset();
    @(negedge clock25MHz);
    reset = 1'b0;
    #1;
    n = 0;
    sb.delete();
    reset_check();
    repeat (2) begin
      @(negedge clock25MHz);
      reset_check();
    end
    reset = 1'b1;
  endtask

  initial begin
    do_reset();
    const_colour = 1'b1;
    run(1700);
    const_colour = 1'b0;
    run(300);
    do_reset();
    run(900);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
